dummy_adc_scan: RTL and testbench
=================================

DUMMY_ADC_SCAN -- requirements
Module: dummy_adc_scan

Interface
REQ-001 Parameter DATA_W, default 16: RESULT width; legal range 9..32.
REQ-002 Parameter NCH, default 8: number of channels; legal range 1..256.
REQ-003 Parameter CONV_CYCLES, default 5: clock cycles per conversion; legal range 1..255.
REQ-004 CLK  input  1  sole clock; all logic on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 START  input  1  scan request; sampled each edge; effective only in IDLE with CH_MASK nonzero.
REQ-007 MODE  input  1  0 = single scan, 1 = continuous scan; latched with START.
REQ-008 STOP  input  1  ends a continuous scan after the current conversion.
REQ-009 CH_MASK  input  NCH  channels to scan; latched with START.
REQ-010 RD  input  1  consumer acknowledge; clears VALID.
REQ-011 BUSY  output  1  high in any state other than IDLE.
REQ-012 DONE  output  1  one-cycle pulse per completed conversion.
REQ-013 VALID  output  1  RESULT holds unread data.
REQ-014 RESULT  output  DATA_W  conversion result.
REQ-015 RESULT_CH  output  8  channel index of RESULT, zero-extended.
REQ-016 OVERRUN  output  1  sticky: result overwritten while unread.

Function
REQ-017 FSM states: IDLE, CONVERT; the only transitions are those in REQ-018..REQ-022.
REQ-018 IDLE to CONVERT on START=1 with CH_MASK!=0: latch MODE and CH_MASK; current channel = lowest set bit; cycle counter = 0; clear OVERRUN.
REQ-019 START while BUSY, or with CH_MASK=0, is ignored: no state change, no flag change.
REQ-020 In CONVERT, counter increments each cycle; on the edge where counter = CONV_CYCLES-1:
- DONE=1 for the next cycle.
- RESULT = {SEQ[DATA_W-9:0], channel[7:0]}.
- RESULT_CH = channel.
- VALID=1.
- SEQ increments mod 2^(DATA_W-8).
- Counter returns to 0.
REQ-021 After a conversion, the next channel is the next higher set bit of the latched mask; CONVERT continues with no idle gap, so DONE pulses are spaced exactly CONV_CYCLES apart.
REQ-022 End of scan (no higher set bit):
- MODE=0: return to IDLE.
- MODE=1, STOP not yet seen: wrap to the lowest set bit and continue.
- MODE=1, STOP seen since the scan began: return to IDLE.
STOP is recorded when sampled high at any time during a continuous scan.
REQ-023 Latency: the first DONE is high in the cycle CONV_CYCLES edges after the edge that samples START.
REQ-024 RD=1 clears VALID on the next edge; RD while VALID=0 has no effect.
REQ-025 A conversion completing while VALID=1 and RD=0 sets OVERRUN and overwrites RESULT.
REQ-026 RD=1 on the same edge as a conversion completes leaves VALID=1 and does not set OVERRUN.
REQ-027 CH_MASK and MODE changes during a scan have no effect until the next START.
REQ-028 BUSY falls on the same edge that produces the final DONE of a scan.

Reset
REQ-029 RST=1 asynchronously forces the following, aborting any conversion in progress:
- state IDLE; counter and SEQ = 0; STOP record cleared.
- BUSY, DONE, VALID, OVERRUN = 0.
- RESULT = 0; RESULT_CH = 0.
REQ-030 The first START is honoured on the first edge after RST deasserts.

Structure
REQ-031 Shared package dummy_adc_pkg holds the state encoding and the RESULT field-split constant 8.
REQ-032 One sub-module, adc_chan_sel: combinational next-set-bit finder.
- Inputs: mask and current index.
- Outputs: next index and a wrap flag.
- Also used for the lowest-set-bit search.

Verification (NCH=8, CONV_CYCLES=5, DATA_W=16)
REQ-033 Single-channel scan: START with MASK=8'h04, MODE=0 -> DONE 5 cycles later; RESULT=16'h0002; BUSY falls the same edge; no further DONE.
REQ-034 Sparse mask: MASK=8'h91, MODE=0, RD each DONE -> three DONEs 5 cycles apart with RESULT_CH 0, 4, 7 and RESULT 16'h0000, 16'h0104, 16'h0207.
REQ-035 Continuous with stop: MASK=8'h03, MODE=1, STOP pulsed during the 3rd conversion -> DONE sequence ch0, ch1, ch0, ch1, then IDLE.
REQ-036 Read/overrun timing:
- No RD across two DONEs -> OVERRUN=1 and RESULT holds the second value.
- RD coincident with a DONE -> VALID stays 1, no overrun.
REQ-037 Reset and ignored requests:
- RST asserted mid-conversion -> all outputs 0 immediately; next START restarts with SEQ=0.
- START while BUSY, or START with MASK=0 -> ignored.

Source files
------------

// File: rtl/dummy_adc_pkg.sv
// Shared definitions for the dummy ADC scanner: FSM encoding, RESULT field split
// and the latched per-scan configuration.
package dummy_adc_pkg;

    // RESULT = {seq, channel}; the channel field is this wide, as is RESULT_CH
    localparam int CH_W = 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CONVERT = 1'b1;

    typedef struct packed {
        logic mode;       // 1 = continuous
        logic stop_seen;  // STOP sampled since this scan began
    } scan_cfg_t;

endpackage

// File: rtl/adc_chan_sel.sv
// Combinational next-set-bit finder: lowest set bit above cur, else wraps to the
// lowest set bit overall. With cur at the top index it yields the lowest set bit.
module adc_chan_sel
    import dummy_adc_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] cur,
    output logic [CH_W-1:0] nxt,
    output logic            wrap
);

    logic [CH_W-1:0] hi_idx;
    logic [CH_W-1:0] lo_idx;
    logic            hi_found;

    // Walking downward lets the last hit win, i.e. the lowest qualifying bit.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx = CH_W'(i);
                if (CH_W'(i) > cur) begin
                    hi_idx   = CH_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign nxt  = hi_found ? hi_idx : lo_idx;
    assign wrap = ~hi_found;

endmodule

// File: rtl/dummy_adc_scan.sv
// Dummy multi-channel ADC scanner: walks the set bits of a channel mask, producing
// one synthetic result every CONV_CYCLES clocks, in single or continuous mode.
module dummy_adc_scan
    import dummy_adc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NCH         = 8,
    parameter int CONV_CYCLES = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              MODE,
    input  logic              STOP,
    input  logic [NCH-1:0]    CH_MASK,
    input  logic              RD,
    output logic              BUSY,
    output logic              DONE,
    output logic              VALID,
    output logic [DATA_W-1:0] RESULT,
    output logic [CH_W-1:0]   RESULT_CH,
    output logic              OVERRUN
);

    localparam int              SEQ_W    = DATA_W - CH_W;
    localparam logic [7:0]      LAST_CNT = 8'(CONV_CYCLES - 1);
    localparam logic [CH_W-1:0] TOP_CH   = CH_W'(NCH - 1);

    logic [0:0]        state;
    logic [7:0]        cnt;
    logic [CH_W-1:0]   chan;
    logic [SEQ_W-1:0]  seq;
    logic [NCH-1:0]    mask_q;
    scan_cfg_t         cfg;

    logic              done_q;
    logic              valid_q;
    logic              ovr_q;
    logic [DATA_W-1:0] result_q;
    logic [CH_W-1:0]   result_ch_q;

    logic [CH_W-1:0]   nxt_ch;
    logic              nxt_wrap;
    logic [CH_W-1:0]   first_ch;
    logic              first_wrap;
    logic              start_ok;
    logic              conv_end;
    logic              scan_end;

    adc_chan_sel #(.NCH(NCH)) u_next (
        .mask (mask_q),
        .cur  (chan),
        .nxt  (nxt_ch),
        .wrap (nxt_wrap)
    );

    // Searching above the top index always wraps, landing on the lowest set bit.
    adc_chan_sel #(.NCH(NCH)) u_first (
        .mask (CH_MASK),
        .cur  (TOP_CH),
        .nxt  (first_ch),
        .wrap (first_wrap)
    );

    assign start_ok = START && (|CH_MASK) && first_wrap;
    assign conv_end = (state == ST_CONVERT) && (cnt == LAST_CNT);
    // STOP sampled on the final edge of a pass counts as already seen.
    assign scan_end = nxt_wrap && (!cfg.mode || cfg.stop_seen || STOP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            chan        <= '0;
            seq         <= '0;
            mask_q      <= '0;
            cfg         <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            result_q    <= '0;
            result_ch_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (RD) valid_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state         <= ST_CONVERT;
                        mask_q        <= CH_MASK;
                        cfg.mode      <= MODE;
                        cfg.stop_seen <= 1'b0;
                        chan          <= first_ch;
                        cnt           <= '0;
                        ovr_q         <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    if (cfg.mode && STOP) cfg.stop_seen <= 1'b1;
                    if (conv_end) begin
                        cnt         <= '0;
                        done_q      <= 1'b1;
                        valid_q     <= 1'b1;
                        result_q    <= {seq, chan};
                        result_ch_q <= chan;
                        seq         <= seq + 1'b1;
                        chan        <= nxt_ch;
                        // A read on the completing edge consumes the old result.
                        if (valid_q && !RD) ovr_q <= 1'b1;
                        if (scan_end) state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY      = (state != ST_IDLE);
    assign DONE      = done_q;
    assign VALID     = valid_q;
    assign OVERRUN   = ovr_q;
    assign RESULT    = result_q;
    assign RESULT_CH = result_ch_q;

endmodule

// File: tb/tb_dummy_adc_scan.sv
// Directed bench for dummy_adc_scan (DATA_W=16, NCH=8, CONV_CYCLES=5): a per-cycle
// vector table plus hand-written continuous, overrun and reset sequences.
module tb_dummy_adc_scan;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START, MODE, STOP, RD;
    logic [7:0]  CH_MASK;
    logic        BUSY, DONE, VALID, OVERRUN;
    logic [15:0] RESULT;
    logic [7:0]  RESULT_CH;

    int n_chk  = 0;
    int n_fail = 0;

    dummy_adc_scan #(.DATA_W(16), .NCH(8), .CONV_CYCLES(5)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .MODE      (MODE),
        .STOP      (STOP),
        .CH_MASK   (CH_MASK),
        .RD        (RD),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .VALID     (VALID),
        .RESULT    (RESULT),
        .RESULT_CH (RESULT_CH),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, start, mode, stop;
        logic [7:0]  mask;
        logic        rd;
        logic        busy, done, valid;
        logic [15:0] result;
        logic [7:0]  ch;
        logic        ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, start, mode, stop, input logic [7:0] mask,
                       input logic rd, busy, done, valid, input logic [15:0] result,
                       input logic [7:0] ch, input logic ovr);
        vec_t v;
        v.rst = rst; v.start = start; v.mode = mode; v.stop = stop; v.mask = mask;
        v.rd = rd; v.busy = busy; v.done = done; v.valid = valid;
        v.result = result; v.ch = ch; v.ovr = ovr;
        tbl.push_back(v);
    endtask

    // n quiet cycles with no DONE expected
    task automatic add_wait(input int n, input logic busy, valid,
                            input logic [15:0] result, input logic [7:0] ch, input logic ovr);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 8'h00, 0, busy, 1'b0, valid, result, ch, ovr);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        START = 0; MODE = 0; STOP = 0; RD = 0; CH_MASK = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        step();
        RST = 0;
    endtask

    int dk[8];
    int dch[8];
    int nd;

    initial begin
        RST = 1;
        idle_inputs();

        // reset state
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 8'd0, 0);
        // single channel 2
        add(0, 1, 0, 0, 8'h04, 0, 1, 0, 0, 16'h0000, 8'd0, 0);
        add_wait(4, 1, 0, 16'h0000, 8'd0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 16'h0002, 8'd2, 0);
        add_wait(2, 0, 1, 16'h0002, 8'd2, 0);
        add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 16'h0002, 8'd2, 0);
        add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 16'h0002, 8'd2, 0);
        // sparse mask 0x91, read after each DONE
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 8'd0, 0);
        add(0, 1, 0, 0, 8'h91, 0, 1, 0, 0, 16'h0000, 8'd0, 0);
        add_wait(4, 1, 0, 16'h0000, 8'd0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 16'h0000, 8'd0, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000, 8'd0, 0);
        add_wait(3, 1, 0, 16'h0000, 8'd0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 16'h0104, 8'd4, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0104, 8'd4, 0);
        add_wait(3, 1, 0, 16'h0104, 8'd4, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 16'h0207, 8'd7, 0);
        add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 16'h0207, 8'd7, 0);
        add_wait(3, 0, 0, 16'h0207, 8'd7, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            RST = tbl[i].rst; START = tbl[i].start; MODE = tbl[i].mode;
            STOP = tbl[i].stop; CH_MASK = tbl[i].mask; RD = tbl[i].rd;
            step();
            chk($sformatf("v%0d BUSY", i),      32'(BUSY),      32'(tbl[i].busy));
            chk($sformatf("v%0d DONE", i),      32'(DONE),      32'(tbl[i].done));
            chk($sformatf("v%0d VALID", i),     32'(VALID),     32'(tbl[i].valid));
            chk($sformatf("v%0d RESULT", i),    32'(RESULT),    32'(tbl[i].result));
            chk($sformatf("v%0d RESULT_CH", i), 32'(RESULT_CH), 32'(tbl[i].ch));
            chk($sformatf("v%0d OVERRUN", i),   32'(OVERRUN),   32'(tbl[i].ovr));
        end
        RST = 0;

        // continuous scan of ch0/ch1, STOP during the 3rd conversion;
        // MODE/CH_MASK changes mid-scan must be ignored
        do_reset();
        START = 1; MODE = 1; CH_MASK = 8'h03;
        step();
        START = 0;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            STOP = (k == 12);
            if (k == 2) begin MODE = 0; CH_MASK = 8'hFF; end
            step();
            if (DONE) begin
                if (nd < 8) begin dk[nd] = k; dch[nd] = int'(RESULT_CH); end
                nd++;
            end
        end
        STOP = 0;
        chk("cont DONE count", 32'(nd), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("cont DONE%0d channel", j), 32'(dch[j]), 32'(j % 2));
            chk($sformatf("cont DONE%0d cycle", j),   32'(dk[j]),  32'(5 * (j + 1)));
        end
        chk("cont BUSY after stop", 32'(BUSY), 32'd0);

        // overrun: two DONEs unread, then a fresh START clears it
        do_reset();
        START = 1; MODE = 0; CH_MASK = 8'h03;
        step();
        START = 0; CH_MASK = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 5) chk("ovr first DONE", 32'(DONE), 32'd1);
        end
        chk("ovr DONE2",    32'(DONE),    32'd1);
        chk("ovr OVERRUN",  32'(OVERRUN), 32'd1);
        chk("ovr RESULT",   32'(RESULT),  32'h0101);
        chk("ovr VALID",    32'(VALID),   32'd1);
        chk("ovr BUSY",     32'(BUSY),    32'd0);
        START = 1; CH_MASK = 8'h01;
        step();
        START = 0; CH_MASK = 8'h00;
        chk("restart clears OVERRUN", 32'(OVERRUN), 32'd0);
        chk("restart keeps VALID",    32'(VALID),   32'd1);
        // RD coincident with completion: VALID stays, no overrun
        for (int k = 1; k <= 5; k++) begin
            RD = (k == 5);
            step();
        end
        chk("rdcoinc DONE",    32'(DONE),    32'd1);
        chk("rdcoinc VALID",   32'(VALID),   32'd1);
        chk("rdcoinc OVERRUN", 32'(OVERRUN), 32'd0);
        chk("rdcoinc RESULT",  32'(RESULT),  32'h0200);
        RD = 1;
        step();
        RD = 0;
        chk("rd clears VALID", 32'(VALID), 32'd0);

        // ignored START while busy, async reset mid-conversion, SEQ restart
        do_reset();
        START = 1; CH_MASK = 8'h06;
        step();
        START = 0; CH_MASK = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            START = (k == 2);
            CH_MASK = (k == 2) ? 8'h80 : 8'h00;
            step();
        end
        START = 0; CH_MASK = 8'h00;
        chk("busy START ignored DONE", 32'(DONE),      32'd1);
        chk("busy START ignored ch",   32'(RESULT_CH), 32'd1);
        chk("busy START ignored res",  32'(RESULT),    32'h0001);
        step();
        step();
        #2 RST = 1;
        #1;
        chk("async rst BUSY",   32'(BUSY),      32'd0);
        chk("async rst VALID",  32'(VALID),     32'd0);
        chk("async rst RESULT", 32'(RESULT),    32'd0);
        chk("async rst CH",     32'(RESULT_CH), 32'd0);
        chk("async rst DONE",   32'(DONE),      32'd0);
        chk("async rst OVR",    32'(OVERRUN),   32'd0);
        #1 RST = 0;
        START = 1; CH_MASK = 8'h08;
        step();
        START = 0; CH_MASK = 8'h00;
        chk("first START after rst", 32'(BUSY), 32'd1);
        for (int k = 1; k <= 5; k++) step();
        chk("post-rst DONE",   32'(DONE),   32'd1);
        chk("post-rst RESULT", 32'(RESULT), 32'h0003);
        START = 1; CH_MASK = 8'h00;
        step();
        START = 0;
        step();
        chk("zero-mask START BUSY",  32'(BUSY),    32'd0);
        chk("zero-mask START VALID", 32'(VALID),   32'd1);
        chk("zero-mask START OVR",   32'(OVERRUN), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
